// File: rtl/ga_pkg.sv
// Shared constants and types for the gate-array sync/interrupt stage.
package ga_pkg;

    // HSYNC falling edges between raster interrupts
    localparam int unsigned INT_LINES = 52;
    // Characters from CRTC HSYNC rise to HSYNC_OUT rise
    localparam int unsigned HS_DELAY  = 2;
    // Maximum HSYNC_OUT width in characters
    localparam int unsigned HS_WIDTH  = 4;
    // VSYNC_OUT width in lines
    localparam int unsigned VS_LINES  = 26;
    // HSYNC falling edges after VSYNC rise before the interrupt resync
    localparam int unsigned VS_RESYNC = 2;

    // Screen mode as seen by the pixel serialiser
    typedef enum logic [1:0] {
        Mode160x16 = 2'd0,  // 160x200, 16 colours
        Mode320x4  = 2'd1,  // 320x200, 4 colours
        Mode640x2  = 2'd2,  // 640x200, 2 colours
        Mode160x4  = 2'd3   // 160x200, 4 colours
    } ga_mode_e;

endpackage

// File: rtl/ga_edge_det.sv
// Rise/fall detector for a CRTC sync line, sampled on the character clock enable.
module ga_edge_det (
    input  logic CLOCK,
    input  logic nRESET,
    input  logic CLKEN,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // Previous-character sample of the sync line
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            sig_q <= 1'b0;
        end else if (CLKEN) begin
            sig_q <= sig;
        end
    end

    assign rise = CLKEN & sig & ~sig_q;
    assign fall = CLKEN & ~sig & sig_q;

endmodule

// File: rtl/ga_sync_int.sv
// Gate-array sync and raster interrupt stage downstream of the CRTC.
module ga_sync_int
    import ga_pkg::*;
(
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       CLKEN,
    input  logic       HSYNC_IN,
    input  logic       VSYNC_IN,
    input  logic       INT_ACK,
    input  logic       IRQ_CLR,
    input  logic       MODE_WR,
    input  logic [1:0] MODE_IN,
    output logic       INT,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic [1:0] MODE,
    output logic [5:0] LINE_CNT
);

    localparam logic [3:0] HsOn    = 4'(HS_DELAY);
    localparam logic [3:0] HsOff   = 4'(HS_DELAY + HS_WIDTH);
    localparam logic [5:0] IntLast = 6'(INT_LINES - 1);
    localparam logic [4:0] VsLast  = 5'(VS_LINES - 1);
    localparam logic [1:0] RsLast  = 2'(VS_RESYNC - 1);

    logic hs_rise, hs_fall;
    logic vs_rise, vs_fall_unused;

    ga_edge_det u_hs_edge (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .CLKEN  (CLKEN),
        .sig    (HSYNC_IN),
        .rise   (hs_rise),
        .fall   (hs_fall)
    );

    ga_edge_det u_vs_edge (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .CLKEN  (CLKEN),
        .sig    (VSYNC_IN),
        .rise   (vs_rise),
        .fall   (vs_fall_unused)
    );

    // ------------------------------------------------------------------
    // Horizontal sync
    // ------------------------------------------------------------------
    logic [3:0] hc_q;
    logic       hs_out_q;
    logic       hs_on;

    // hc holds a stale value between lines, so the rise must exclude hs_rise itself
    assign hs_on = CLKEN & HSYNC_IN & ~hs_rise & (hc_q == HsOn);

    // Characters since CRTC HSYNC rise, saturating
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            hc_q <= 4'd0;
        end else if (CLKEN) begin
            if (hs_rise) begin
                hc_q <= 4'd1;
            end else if (HSYNC_IN && hc_q != 4'hf) begin
                hc_q <= hc_q + 4'd1;
            end
        end
    end

    // HSYNC_OUT: width limit or CRTC fall terminates, whichever comes first
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            hs_out_q <= 1'b0;
        end else if (hs_fall || (CLKEN && hc_q == HsOff)) begin
            hs_out_q <= 1'b0;
        end else if (hs_on) begin
            hs_out_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Mode latch
    // ------------------------------------------------------------------
    ga_mode_e pend_q;
    ga_mode_e mode_q;

    // Pending mode from the CPU write, applied only at HSYNC_OUT rise
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            pend_q <= Mode160x16;
            mode_q <= Mode160x16;
        end else begin
            if (MODE_WR) begin
                pend_q <= ga_mode_e'(MODE_IN);
            end
            if (hs_on) begin
                mode_q <= pend_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // VSYNC resync counter
    // ------------------------------------------------------------------
    logic       armed_q;
    logic [1:0] rs_q;
    logic       resync_hit;

    assign resync_hit = hs_fall & armed_q & ~vs_rise & (rs_q == RsLast);

    // Counts HSYNC falls after VSYNC rise; a new VSYNC rise restarts it
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            armed_q <= 1'b0;
            rs_q    <= 2'd0;
        end else if (vs_rise) begin
            armed_q <= 1'b1;
            rs_q    <= 2'd0;
        end else if (hs_fall && armed_q) begin
            if (rs_q == RsLast) begin
                armed_q <= 1'b0;
                rs_q    <= 2'd0;
            end else begin
                rs_q <= rs_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vertical sync
    // ------------------------------------------------------------------
    logic       vs_out_q;
    logic [4:0] vl_q;

    // Fixed-length VSYNC_OUT counted in HSYNC falls, retriggerable
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            vs_out_q <= 1'b0;
            vl_q     <= 5'd0;
        end else if (vs_rise) begin
            vs_out_q <= 1'b1;
            vl_q     <= 5'd0;
        end else if (hs_fall && vs_out_q) begin
            if (vl_q == VsLast) begin
                vs_out_q <= 1'b0;
                vl_q     <= 5'd0;
            end else begin
                vl_q <= vl_q + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster interrupt
    // ------------------------------------------------------------------
    logic       clr_q;
    logic       clr_act;
    logic       clr_now;
    logic       int_q, int_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] cnt_base;

    // IRQ_CLR between character strobes is held until the next one
    assign clr_act = IRQ_CLR | clr_q;
    assign clr_now = CLKEN & clr_act;

    // Next interrupt state; acknowledge clears bit 5 before any increment
    always_comb begin
        cnt_base = INT_ACK ? {1'b0, cnt_q[4:0]} : cnt_q;
        cnt_d    = cnt_base;
        int_d    = INT_ACK ? 1'b0 : int_q;
        if (clr_now) begin
            cnt_d = 6'd0;
            int_d = 1'b0;
        end else if (hs_fall) begin
            if (resync_hit) begin
                if (cnt_base >= 6'd32) begin
                    int_d = 1'b1;
                end
                cnt_d = 6'd0;
            end else if (cnt_base == IntLast) begin
                cnt_d = 6'd0;
                int_d = 1'b1;
            end else begin
                cnt_d = cnt_base + 6'd1;
            end
        end
    end

    // Interrupt state registers
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            clr_q <= 1'b0;
            int_q <= 1'b0;
            cnt_q <= 6'd0;
        end else begin
            clr_q <= clr_act & ~CLKEN;
            int_q <= int_d;
            cnt_q <= cnt_d;
        end
    end

    assign INT       = int_q;
    assign HSYNC_OUT = hs_out_q;
    assign VSYNC_OUT = vs_out_q;
    assign MODE      = mode_q;
    assign LINE_CNT  = cnt_q;

endmodule

// File: tb/tb_ga_sync_int.sv
// Directed bench for the gate-array sync/interrupt stage.
module tb_ga_sync_int;

    logic       CLOCK    = 1'b0;
    logic       nRESET   = 1'b0;
    logic       CLKEN    = 1'b0;
    logic       HSYNC_IN = 1'b0;
    logic       VSYNC_IN = 1'b0;
    logic       INT_ACK  = 1'b0;
    logic       IRQ_CLR  = 1'b0;
    logic       MODE_WR  = 1'b0;
    logic [1:0] MODE_IN  = 2'd0;
    logic       INT;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    logic [1:0] MODE;
    logic [5:0] LINE_CNT;

    int n_pass  = 0;
    int n_total = 0;

    ga_sync_int dut (
        .CLOCK     (CLOCK),
        .nRESET    (nRESET),
        .CLKEN     (CLKEN),
        .HSYNC_IN  (HSYNC_IN),
        .VSYNC_IN  (VSYNC_IN),
        .INT_ACK   (INT_ACK),
        .IRQ_CLR   (IRQ_CLR),
        .MODE_WR   (MODE_WR),
        .MODE_IN   (MODE_IN),
        .INT       (INT),
        .HSYNC_OUT (HSYNC_OUT),
        .VSYNC_OUT (VSYNC_OUT),
        .MODE      (MODE),
        .LINE_CNT  (LINE_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    // One horizontal-timing/mode vector: CRTC HSYNC width, mode written before the line,
    // first character index with HSYNC_OUT high (-1 = never), HSYNC_OUT width, MODE after line
    typedef struct {
        int width;
        int mode_wr;
        int exp_first;
        int exp_high;
        int exp_mode;
    } hvec_t;

    hvec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One character: inputs applied with a single-CLOCK CLKEN, then one idle CLOCK
    task automatic char_step(input logic hs, input logic vs, input logic clr);
        HSYNC_IN = hs;
        VSYNC_IN = vs;
        IRQ_CLR  = clr;
        CLKEN    = 1'b1;
        @(posedge CLOCK); #1;
        CLKEN    = 1'b0;
        IRQ_CLR  = 1'b0;
        @(posedge CLOCK); #1;
    endtask

    task automatic run_line(input int width, input int len, input logic vs);
        for (int c = 0; c < len; c++) char_step(c < width, vs, 1'b0);
    endtask

    task automatic run_lines(input int n, input logic vs);
        for (int i = 0; i < n; i++) run_line(14, 20, vs);
    endtask

    task automatic pulse_ack();
        INT_ACK = 1'b1;
        @(posedge CLOCK); #1;
        INT_ACK = 1'b0;
    endtask

    task automatic pulse_clr();
        IRQ_CLR = 1'b1;
        @(posedge CLOCK); #1;
        IRQ_CLR = 1'b0;
    endtask

    initial begin
        int first;
        int high;
        int mid;
        int prev_mode;

        vecs[0] = '{width: 14, mode_wr: 1, exp_first:  2, exp_high: 4, exp_mode: 1};
        vecs[1] = '{width:  2, mode_wr: 2, exp_first: -1, exp_high: 0, exp_mode: 1};
        vecs[2] = '{width:  5, mode_wr: 2, exp_first:  2, exp_high: 3, exp_mode: 2};
        vecs[3] = '{width:  1, mode_wr: 3, exp_first: -1, exp_high: 0, exp_mode: 2};
        vecs[4] = '{width:  3, mode_wr: 3, exp_first:  2, exp_high: 1, exp_mode: 3};
        vecs[5] = '{width:  6, mode_wr: 2, exp_first:  2, exp_high: 4, exp_mode: 2};

        // Reset state
        #3;
        check("rst_int", int'(INT), 0);
        check("rst_hsync", int'(HSYNC_OUT), 0);
        check("rst_vsync", int'(VSYNC_OUT), 0);
        check("rst_mode", int'(MODE), 0);
        check("rst_line_cnt", int'(LINE_CNT), 0);
        #4 nRESET = 1'b1;
        @(posedge CLOCK); #1;

        // Horizontal timing and mode latch, one line per vector
        prev_mode = 0;
        for (int r = 0; r < 6; r++) begin
            first = -1;
            high  = 0;
            mid   = -1;
            MODE_IN = 2'(vecs[r].mode_wr);
            MODE_WR = 1'b1;
            @(posedge CLOCK); #1;
            MODE_WR = 1'b0;
            for (int c = 0; c < 20; c++) begin
                char_step(c < vecs[r].width, 1'b0, 1'b0);
                if (HSYNC_OUT) begin
                    if (first < 0) first = c;
                    high++;
                end
                if (c == 1) mid = int'(MODE);
            end
            check($sformatf("hs_first[%0d]", r), first, vecs[r].exp_first);
            check($sformatf("hs_width[%0d]", r), high, vecs[r].exp_high);
            check($sformatf("mode_mid[%0d]", r), mid, prev_mode);
            check($sformatf("mode_end[%0d]", r), int'(MODE), vecs[r].exp_mode);
            prev_mode = vecs[r].exp_mode;
        end
        check("tbl_line_cnt", int'(LINE_CNT), 6);

        // Reset asserted mid-HSYNC_OUT with VSYNC_OUT and MODE non-zero
        for (int c = 0; c < 3; c++) char_step(1'b1, 1'b1, 1'b0);
        check("pre_rst_hsync", int'(HSYNC_OUT), 1);
        check("pre_rst_vsync", int'(VSYNC_OUT), 1);
        nRESET = 1'b0;
        #1;
        check("mid_rst_int", int'(INT), 0);
        check("mid_rst_hsync", int'(HSYNC_OUT), 0);
        check("mid_rst_vsync", int'(VSYNC_OUT), 0);
        check("mid_rst_mode", int'(MODE), 0);
        check("mid_rst_line_cnt", int'(LINE_CNT), 0);
        HSYNC_IN = 1'b0;
        VSYNC_IN = 1'b0;
        #2 nRESET = 1'b1;
        @(posedge CLOCK); #1;
        for (int c = 0; c < 4; c++) char_step(1'b0, 1'b0, 1'b0);

        // Free run, 64-character lines, HSYNC width 14
        for (int i = 0; i < 51; i++) run_line(14, 64, 1'b0);
        check("free_cnt51", int'(LINE_CNT), 51);
        check("free_int51", int'(INT), 0);
        run_line(14, 64, 1'b0);
        check("free_int52", int'(INT), 1);
        check("free_wrap", int'(LINE_CNT), 0);

        // Acknowledge at line 40 clears INT and bit 5
        run_lines(40, 1'b0);
        check("ack_pre_cnt", int'(LINE_CNT), 40);
        check("ack_pre_int", int'(INT), 1);
        pulse_ack();
        check("ack_int", int'(INT), 0);
        check("ack_cnt", int'(LINE_CNT), 8);
        run_lines(43, 1'b0);
        check("ack_cnt51", int'(LINE_CNT), 51);
        check("ack_int51", int'(INT), 0);
        run_lines(1, 1'b0);
        check("ack_next_int", int'(INT), 1);
        check("ack_next_cnt", int'(LINE_CNT), 0);

        // VSYNC at LINE_CNT=33: resync raises INT; CRTC VSYNC 8 lines wide
        pulse_ack();
        run_lines(33, 1'b0);
        check("rsA_cnt33", int'(LINE_CNT), 33);
        run_lines(1, 1'b1);
        check("rsA_cnt_fall1", int'(LINE_CNT), 34);
        check("rsA_int_fall1", int'(INT), 0);
        check("rsA_vsync_on", int'(VSYNC_OUT), 1);
        run_lines(1, 1'b1);
        check("rsA_int", int'(INT), 1);
        check("rsA_cnt", int'(LINE_CNT), 0);
        run_lines(6, 1'b1);
        run_lines(17, 1'b0);
        check("vsA_line25", int'(VSYNC_OUT), 1);
        run_lines(1, 1'b0);
        check("vsA_line26", int'(VSYNC_OUT), 0);
        check("rsA_cnt_after", int'(LINE_CNT), 24);

        // VSYNC at LINE_CNT=20: counter resyncs without INT; retrigger at line 10
        pulse_ack();
        pulse_clr();
        run_lines(20, 1'b0);
        check("rsB_cnt20", int'(LINE_CNT), 20);
        run_lines(1, 1'b1);
        check("rsB_cnt_fall1", int'(LINE_CNT), 21);
        run_lines(1, 1'b1);
        check("rsB_cnt", int'(LINE_CNT), 0);
        check("rsB_int", int'(INT), 0);
        run_lines(8, 1'b0);
        run_lines(2, 1'b1);
        check("rsB_retrig_cnt", int'(LINE_CNT), 0);
        run_lines(14, 1'b0);
        check("vsB_line26", int'(VSYNC_OUT), 1);
        run_lines(9, 1'b0);
        check("vsB_line35", int'(VSYNC_OUT), 1);
        run_lines(1, 1'b0);
        check("vsB_line36", int'(VSYNC_OUT), 0);
        check("rsB_cnt_after", int'(LINE_CNT), 24);

        // IRQ_CLR coinciding with the 52nd HSYNC fall
        run_lines(27, 1'b0);
        check("clr_pre_cnt", int'(LINE_CNT), 51);
        for (int c = 0; c < 14; c++) char_step(1'b1, 1'b0, 1'b0);
        char_step(1'b0, 1'b0, 1'b1);
        check("clr_cnt", int'(LINE_CNT), 0);
        check("clr_int", int'(INT), 0);
        for (int c = 15; c < 20; c++) char_step(1'b0, 1'b0, 1'b0);
        run_lines(1, 1'b0);
        check("clr_next_cnt", int'(LINE_CNT), 1);
        check("clr_next_int", int'(INT), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
